seq_div_nbit: RTL and testbench

- Multi-cycle signed two's-complement integer divider for the PE datapath. It is the inverse arithmetic path to the N-bit add/subtract and multiply logic.
- Uses non-restoring division: one add/subtract step per clock, one quotient bit per cycle.
- Results truncate toward zero. The remainder takes the sign of the dividend.
- Start/done handshake, so a PE controller can issue one division and wait for it to finish.

---
 rtl/seq_div_nbit_if.sv | 25 ++
 rtl/seq_div_nbit.sv | 150 +++++++++++++++
 tb/tb_seq_div_nbit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_nbit_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master issues start/operands; the slave (divider) returns status and results.
interface seq_div_nbit_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, ovf
    );
endinterface

// File: rtl/seq_div_nbit.sv
// Multi-cycle signed divider, non-restoring, one quotient bit per cycle.
// Quotient truncates toward zero; remainder carries the dividend's sign.
module seq_div_nbit #(
    parameter int unsigned N = 8
) (
    input logic         clk,
    input logic         rst,
    seq_div_nbit_if.slave bus
);
    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e          state_q, state_d;
    logic [N:0]      p_q, p_d;         // signed partial remainder
    logic [N-1:0]    a_q, a_d;         // dividend magnitude shifting out, quotient shifting in
    logic [N-1:0]    d_q, d_d;         // divisor magnitude
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            dbz_q, dbz_d;
    logic            ovf_pend_q, ovf_pend_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N-1:0]    quotient_q, quotient_d;
    logic [N-1:0]    remainder_q, remainder_d;
    logic            div_by_zero_q, div_by_zero_d;
    logic            ovf_q, ovf_d;

    logic [N-1:0]    dvd_mag, dvs_mag;
    logic [N:0]      p_shift, p_step;
    logic [N-1:0]    r_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            p_q           <= '0;
            a_q           <= '0;
            d_q           <= '0;
            cnt_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            ovf_pend_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            a_q           <= a_d;
            d_q           <= d_d;
            cnt_q         <= cnt_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dbz_q         <= dbz_d;
            ovf_pend_q    <= ovf_pend_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            ovf_q         <= ovf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        a_d           = a_q;
        d_d           = d_q;
        cnt_d         = cnt_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dbz_d         = dbz_q;
        ovf_pend_d    = ovf_pend_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        ovf_d         = ovf_q;
        p_shift       = '0;
        p_step        = '0;
        r_mag         = '0;

        // N-bit unsigned magnitudes, so |-2^(N-1)| still fits
        dvd_mag = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
        dvs_mag = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    q_neg_d    = bus.dividend[N-1] ^ bus.divisor[N-1];
                    r_neg_d    = bus.dividend[N-1];
                    a_d        = dvd_mag;
                    d_d        = dvs_mag;
                    p_d        = '0;
                    cnt_d      = CntW'(N);
                    busy_d     = 1'b1;
                    dbz_d      = (bus.divisor == '0);
                    ovf_pend_d = (bus.dividend == {1'b1, {(N - 1){1'b0}}}) &&
                                 (bus.divisor == '1);
                    state_d    = (bus.divisor == '0) ? StFix : StCalc;
                end
            end
            StCalc: begin
                // Wrapping to N+1 bits is safe: the true step result lies in [-D, D)
                p_shift = {p_q[N-1:0], a_q[N-1]};
                p_step  = p_q[N] ? (p_shift + {1'b0, d_q}) : (p_shift - {1'b0, d_q});
                p_d     = p_step;
                a_d     = {a_q[N-2:0], ~p_step[N]};
                cnt_d   = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                r_mag = p_q[N] ? (p_q[N-1:0] + d_q) : p_q[N-1:0];
                if (dbz_q) begin
                    // a_q still holds the untouched dividend magnitude
                    quotient_d    = '1;
                    remainder_d   = r_neg_q ? -a_q : a_q;
                    div_by_zero_d = 1'b1;
                    ovf_d         = 1'b0;
                end else begin
                    quotient_d    = q_neg_q ? -a_q : a_q;
                    remainder_d   = r_neg_q ? -r_mag : r_mag;
                    div_by_zero_d = 1'b0;
                    ovf_d         = ovf_pend_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_seq_div_nbit.sv
// Self-checking bench for seq_div_nbit: directed cases plus random operands
// compared against plain integer division with the divider's special-case rules.
module tb_seq_div_nbit;
    localparam int unsigned N = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    logic [N-1:0] hold_q;
    logic [N-1:0] hold_r;

    seq_div_nbit_if #(.N(N)) bus ();

    seq_div_nbit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division truncating toward zero, plus the two special cases
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] eq, output logic [N-1:0] er,
                         output logic edbz, output logic eovf);
        int sa;
        int sb;
        int q;
        int r;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        edbz = 1'b0;
        eovf = 1'b0;
        if (sb == 0) begin
            q    = -1;
            r    = sa;
            edbz = 1'b1;
        end else if (sa == -(2 ** (N - 1)) && sb == -1) begin
            q    = sa;
            r    = 0;
            eovf = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        eq = q[N-1:0];
        er = r[N-1:0];
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         edbz;
        logic         eovf;
        int           elat;
        int           lat;
        model(a, b, eq, er, edbz, eovf);
        elat = edbz ? 1 : int'(N) + 1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " busy_at_accept"}, 32'(bus.busy), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.done) begin
                check({tag, " busy_mid"}, 32'(bus.busy), 32'd1);
                check({tag, " q_held_mid"}, 32'(bus.quotient), 32'(hold_q));
            end
        end while (!bus.done && lat < 4 * int'(N));
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, " remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edbz));
        check({tag, " ovf"}, 32'(bus.ovf), 32'(eovf));
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        hold_q = eq;
        hold_r = er;
        @(posedge clk);
        #1;
        check({tag, " done_falls"}, 32'(bus.done), 32'd0);
        check({tag, " q_held_after"}, 32'(bus.quotient), 32'(hold_q));
        check({tag, " r_held_after"}, 32'(bus.remainder), 32'(hold_r));
    endtask

    initial begin
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         edbz;
        logic         eovf;
        int           lat;
        int           done_seen;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        n_cmp        = 0;
        n_fail       = 0;
        hold_q       = '0;
        hold_r       = '0;
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset quotient", 32'(bus.quotient), 32'd0);
        check("reset remainder", 32'(bus.remainder), 32'd0);
        check("reset dbz", 32'(bus.div_by_zero), 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle hold quotient", 32'(bus.quotient), 32'd0);

        do_op(8'd100, 8'd7, "100/7");
        do_op(-8'sd100, 8'd7, "-100/7");
        do_op(8'd100, -8'sd7, "100/-7");
        do_op(-8'sd100, -8'sd7, "-100/-7");
        do_op(8'd5, 8'd9, "5/9");
        do_op(8'd37, 8'd0, "37/0");
        do_op(8'd20, 8'd3, "20/3");
        do_op(8'h80, 8'hFF, "-128/-1");
        do_op(8'h80, 8'd1, "-128/1");
        do_op(-8'sd37, 8'd0, "-37/0");

        // start held high with changing operands: only the captured pair is used,
        // then the next op is accepted the cycle after done
        model(8'd100, 8'd7, eq, er, edbz, eovf);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.done && lat < 4 * int'(N));
        check("hold latency", 32'(lat), 32'(N + 1));
        check("hold quotient", 32'(bus.quotient), 32'(eq));
        check("hold remainder", 32'(bus.remainder), 32'(er));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b done_falls", 32'(bus.done), 32'd0);
        check("b2b busy_accept", 32'(bus.busy), 32'd1);
        model(8'd50, 8'd5, eq, er, edbz, eovf);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.done && lat < 4 * int'(N));
        check("b2b latency", 32'(lat), 32'(N + 1));
        check("b2b quotient", 32'(bus.quotient), 32'(eq));
        check("b2b remainder", 32'(bus.remainder), 32'(er));
        hold_q = eq;
        hold_r = er;
        do_op(8'd100, 8'd7, "pre_reset 100/7");

        // reset during the fourth calculation cycle
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst quotient", 32'(bus.quotient), 32'd0);
        check("midrst remainder", 32'(bus.remainder), 32'd0);
        check("midrst dbz", 32'(bus.div_by_zero), 32'd0);
        check("midrst ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 2 * int'(N); i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        check("midrst no_done", 32'(done_seen), 32'd0);
        hold_q = '0;
        hold_r = '0;
        do_op(8'd100, 8'd7, "post_reset 100/7");

        for (int k = 0; k < 40; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: rb = '1;
                2: ra = 8'h80;
                3: rb = 8'h80;
                default: ;
            endcase
            do_op(ra, rb, $sformatf("rand%0d %0d/%0d", k, $signed(ra), $signed(rb)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
